// File: rtl/sig_accum_pkg.sv
// Shared types and helpers for the signature accumulator: FSM states, MISR step function
// and counter-width helper.
package sig_accum_pkg;

   // Widest signature the MISR step function supports; WIDTH must stay below this.
   localparam int unsigned MaxSigW = 128;

   typedef enum logic [1:0] {
      SA_IDLE,
      SA_WARMUP,
      SA_ACCUM,
      SA_DONE
   } sa_state_e;

   function automatic int unsigned cnt_width(input int unsigned total);
      return $clog2(total + 1);
   endfunction

   localparam int unsigned DefaultCntW = cnt_width(100);

   // One MISR step for a signature of 'width' bits, taps {width-1, 2, 0}; bits above width
   // are don't-care and must be discarded by the caller.
   function automatic logic [MaxSigW-1:0] misr_step(input logic [MaxSigW-1:0] sig,
                                                    input logic [MaxSigW-1:0] din,
                                                    input int unsigned        width);
      logic [MaxSigW-1:0] top_mask;
      logic               fb;
      top_mask = {{(MaxSigW-1){1'b0}}, 1'b1} << (width - 1);
      fb       = (|(sig & top_mask)) ^ sig[2] ^ sig[0];
      return din ^ {sig[MaxSigW-2:0], fb};
   endfunction

endpackage

// File: rtl/sig_misr.sv
// Multiple-input signature register with synchronous clear and enable.
module sig_misr
   import sig_accum_pkg::*;
#(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DIN_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [DIN_W-1:0] din,
   output logic [WIDTH-1:0] sig
);

   logic [MaxSigW-1:0] step;
   logic [WIDTH-1:0]   sig_d, sig_q;
   logic               unused_step;

   always_comb begin
      step  = misr_step(MaxSigW'(sig_q), MaxSigW'(din), WIDTH);
      sig_d = sig_q;
      if (clr) begin
         sig_d = '0;
      end else if (en) begin
         sig_d = step[WIDTH-1:0];
      end
   end

   assign unused_step = ^step[MaxSigW-1:WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_q <= '0;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign sig = sig_q;

endmodule

// File: rtl/sig_accum.sv
// Signature accumulator: discards a warm-up window, folds the remaining beats into a MISR
// and compares the final signature against a golden value.
module sig_accum
   import sig_accum_pkg::*;
#(
   parameter int unsigned     WIDTH        = 64,
   parameter int unsigned     DIN_W        = 8,
   parameter int unsigned     WARMUP_BEATS = 10,
   parameter int unsigned     TOTAL_BEATS  = 100,
   parameter logic [WIDTH-1:0] EXPECTED    = 64'h0
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 start,
   input  logic                                 in_valid,
   input  logic [DIN_W-1:0]                     din,
   output logic                                 in_ready,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 pass,
   output logic                                 fail,
   output logic [WIDTH-1:0]                     signature,
   output logic [cnt_width(TOTAL_BEATS)-1:0]    beat_count
);

   localparam int unsigned     CntW      = cnt_width(TOTAL_BEATS);
   localparam logic [CntW-1:0] WarmLast  = CntW'(WARMUP_BEATS - 1);
   localparam logic [CntW-1:0] TotalLast = CntW'(TOTAL_BEATS - 1);

   sa_state_e          state_q;
   logic [CntW-1:0]    cnt_q;
   logic               run_q, done_q, pass_q, fail_q;
   logic               misr_clr, misr_en;
   logic [MaxSigW-1:0] next_full;
   logic [WIDTH-1:0]   final_sig;
   logic               unused_next;

   assign misr_clr = start && (state_q == SA_IDLE || state_q == SA_DONE);
   assign misr_en  = in_valid && (state_q == SA_ACCUM);

   // Signature including the beat being accepted, so pass/fail is ready with done.
   always_comb begin
      next_full = misr_step(MaxSigW'(signature), MaxSigW'(din), WIDTH);
      final_sig = next_full[WIDTH-1:0];
   end

   assign unused_next = ^next_full[MaxSigW-1:WIDTH];

   sig_misr #(
      .WIDTH (WIDTH),
      .DIN_W (DIN_W)
   ) u_misr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (misr_clr),
      .en    (misr_en),
      .din   (din),
      .sig   (signature)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SA_IDLE;
         cnt_q   <= '0;
         run_q   <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         fail_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            SA_IDLE, SA_DONE: begin
               if (start) begin
                  state_q <= SA_WARMUP;
                  cnt_q   <= '0;
                  run_q   <= 1'b1;
                  pass_q  <= 1'b0;
                  fail_q  <= 1'b0;
               end
            end
            SA_WARMUP: begin
               if (in_valid) begin
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q == WarmLast) begin
                     state_q <= SA_ACCUM;
                  end
               end
            end
            SA_ACCUM: begin
               if (in_valid) begin
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q == TotalLast) begin
                     state_q <= SA_DONE;
                     run_q   <= 1'b0;
                     done_q  <= 1'b1;
                     pass_q  <= (final_sig == EXPECTED);
                     fail_q  <= (final_sig != EXPECTED);
                  end
               end
            end
            default: state_q <= SA_IDLE;
         endcase
      end
   end

   assign in_ready   = run_q;
   assign busy       = run_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign fail       = fail_q;
   assign beat_count = cnt_q;

endmodule

// File: tb/tb_sig_accum.sv
// Directed bench for sig_accum: a short-run instance (1 warm-up / 3 total) and a
// default-parameter instance exercising reset, wrap feedback, bubbles and restart.
module tb_sig_accum;
   import sig_accum_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        start_a, valid_a, ready_a, busy_a, done_a, pass_a, fail_a;
   logic [7:0]  din_a;
   logic [63:0] sig_a;
   logic [1:0]  cnt_a;

   logic        start_b, valid_b, ready_b, busy_b, done_b, pass_b, fail_b;
   logic [7:0]  din_b;
   logic [63:0] sig_b;
   logic [6:0]  cnt_b;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0]  data [100];
   logic [63:0] model;

   sig_accum #(
      .WARMUP_BEATS (1),
      .TOTAL_BEATS  (3),
      .EXPECTED     (64'h3)
   ) dut_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start_a),
      .in_valid   (valid_a),
      .din        (din_a),
      .in_ready   (ready_a),
      .busy       (busy_a),
      .done       (done_a),
      .pass       (pass_a),
      .fail       (fail_a),
      .signature  (sig_a),
      .beat_count (cnt_a)
   );

   sig_accum dut_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start_b),
      .in_valid   (valid_b),
      .din        (din_b),
      .in_ready   (ready_b),
      .busy       (busy_b),
      .done       (done_b),
      .pass       (pass_b),
      .fail       (fail_b),
      .signature  (sig_b),
      .beat_count (cnt_b)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Inputs change on the negedge; returns on the next negedge, after one posedge.
   task automatic drive(input bit sel_a, input logic s, input logic v, input logic [7:0] d);
      if (sel_a) begin
         start_a = s; valid_a = v; din_a = d;
      end else begin
         start_b = s; valid_b = v; din_b = d;
      end
      @(negedge clk);
      start_a = 1'b0; valid_a = 1'b0; din_a = 8'h00;
      start_b = 1'b0; valid_b = 1'b0; din_b = 8'h00;
   endtask

   function automatic logic [63:0] model_step(input logic [63:0] m, input logic [7:0] d);
      return {m[62:0], m[63] ^ m[2] ^ m[0]} ^ {56'h0, d};
   endfunction

   initial begin
      rst_n = 1'b0;
      start_a = 1'b0; valid_a = 1'b0; din_a = 8'h00;
      start_b = 1'b0; valid_b = 1'b0; din_b = 8'h00;
      #12;
      check("rst_sig",   sig_b, 64'h0);
      check("rst_cnt",   64'(cnt_b), 64'd0);
      check("rst_busy",  64'(busy_b), 64'd0);
      check("rst_ready", 64'(ready_b), 64'd0);
      check("rst_flags", {61'd0, done_b, pass_b, fail_b}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Short run: FF discarded, 01 -> 1, 00 -> {1<<1 | fb=1} = 3.
      drive(1'b1, 1'b1, 1'b0, 8'h00);
      check("a_busy", 64'(busy_a), 64'd1);
      drive(1'b1, 1'b0, 1'b1, 8'hFF);
      check("a_warm_sig", sig_a, 64'h0);
      drive(1'b1, 1'b0, 1'b1, 8'h01);
      check("a_sig1", sig_a, 64'h1);
      check("a_done_early", 64'(done_a), 64'd0);
      drive(1'b1, 1'b0, 1'b1, 8'h00);
      check("a_sig2", sig_a, 64'h3);
      check("a_flags", {61'd0, done_a, pass_a, fail_a}, 64'b110);
      check("a_cnt", 64'(cnt_a), 64'd3);
      drive(1'b1, 1'b0, 1'b1, 8'h00);
      check("a_after", {61'd0, done_a, pass_a, fail_a}, 64'b010);
      check("a_frozen", sig_a, 64'h3);

      // Asynchronous reset mid-accumulation.
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 40; i++) drive(1'b0, 1'b0, 1'b1, 8'($urandom_range(1, 255)));
      check("r_cnt40", 64'(cnt_b), 64'd40);
      #2 rst_n = 1'b0;
      #1;
      check("r_sig",   sig_b, 64'h0);
      check("r_cnt",   64'(cnt_b), 64'd0);
      check("r_ctl",   {60'd0, busy_b, ready_b, done_b, pass_b}, 64'd0);
      check("r_state", 64'(dut_b.state_q), 64'(SA_IDLE));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // All-zero run, EXPECTED = 0.
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 100; i++) begin
         drive(1'b0, 1'b0, 1'b1, 8'h00);
         if (i == 9) check("z_cnt10", 64'(cnt_b), 64'd10);
      end
      check("z_flags", {61'd0, done_b, pass_b, fail_b}, 64'b110);
      check("z_cnt",   64'(cnt_b), 64'd100);
      drive(1'b0, 1'b0, 1'b1, 8'h55);
      check("z_hold",  {61'd0, done_b, pass_b, fail_b}, 64'b010);
      check("z_cnt_frozen", 64'(cnt_b), 64'd100);
      check("z_sig_frozen", sig_b, 64'h0);

      // Wrap: walk a single one up to bit 63 (din cancels taps 0 and 2), then wrap.
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 1'b1, 8'hFF);
      check("w_warm_sig", sig_b, 64'h0);
      drive(1'b0, 1'b0, 1'b1, 8'h01);
      drive(1'b0, 1'b0, 1'b1, 8'h01);
      drive(1'b0, 1'b0, 1'b1, 8'h00);
      drive(1'b0, 1'b0, 1'b1, 8'h01);
      check("w_sig8", sig_b, 64'h8);
      for (int i = 0; i < 60; i++) drive(1'b0, 1'b0, 1'b1, 8'h00);
      check("w_msb", sig_b, 64'h8000_0000_0000_0000);
      drive(1'b0, 1'b0, 1'b1, 8'h00);
      check("w_wrap", sig_b, 64'h1);
      for (int i = 0; i < 25; i++) drive(1'b0, 1'b0, 1'b1, 8'h00);
      check("w_flags", {61'd0, done_b, pass_b, fail_b}, 64'b101);

      // Restart from a failed DONE.
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      check("s_flags", {61'd0, done_b, pass_b, fail_b}, 64'd0);
      check("s_cnt",   64'(cnt_b), 64'd0);
      check("s_busy",  64'(busy_b), 64'd1);
      check("s_sig",   sig_b, 64'h0);

      model = 64'h0;
      for (int i = 0; i < 100; i++) begin
         data[i] = 8'(i * 37 + 11);
         if (i >= 10) model = model_step(model, data[i]);
      end
      for (int i = 0; i < 100; i++) drive(1'b0, 1'b0, 1'b1, data[i]);
      check("b2b_sig",   sig_b, model);
      check("b2b_flags", {61'd0, done_b, pass_b, fail_b}, {61'd0, 1'b1, model == 64'h0, model != 64'h0});

      // Same data with bubbles and start pulses mid-run and on the final beat.
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 100; i++) begin
         drive(1'b0, (i == 30), 1'b0, 8'hA5);
         drive(1'b0, (i == 50 || i == 99), 1'b1, data[i]);
         if (i == 50) check("bub_cnt51", 64'(cnt_b), 64'd51);
      end
      check("bub_sig",   sig_b, model);
      check("bub_cnt",   64'(cnt_b), 64'd100);
      check("bub_flags", {61'd0, done_b, pass_b, fail_b}, {61'd0, 1'b1, model == 64'h0, model != 64'h0});
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      check("bub_idle",  {62'd0, busy_b, done_b}, 64'd0);
      check("bub_hold",  sig_b, model);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
